uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 4, number of byte-stream requesters sharing one UART transmit FIFO write port (2..8).
REQ-002 Parameter MAX_BURST, default 16, maximum bytes per grant (1..255).
REQ-003 Parameter IDLE_TIMEOUT, default 64, cycles a granted requester may hold the grant with req_valid low (1..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  high allows new grants.
REQ-007 req_valid  input  REQUESTERS  per-requester byte valid.
REQ-008 req_data  input  8*REQUESTERS  per-requester byte; requester i on bits [8i+7:8i].
REQ-009 req_last  input  REQUESTERS  marks final byte of requester's message.
REQ-010 req_ready  output  REQUESTERS  byte accepted this cycle when valid&ready.
REQ-011 tx_data  output  8  byte to FIFO write port.
REQ-012 tx_we  output  1  FIFO write strobe.
REQ-013 tx_full  input  1  FIFO full; no write may be issued while high.
REQ-014 grant_active  output  1  a requester currently holds the grant.
REQ-015 grant_id  output  clog2(REQUESTERS)  index of granted requester.
REQ-016 burst_count  output  8  bytes accepted in current grant.

Function
REQ-017 Two states SHALL exist: IDLE and BURST.
REQ-018 IDLE -> BURST on a clock edge when enable=1 and any req_valid=1; grant_id loads winner, burst_count and idle counter clear.
REQ-019 Winner SHALL be round-robin: first requester with req_valid=1 searching upward from (last_grant+1) modulo REQUESTERS; last_grant resets to REQUESTERS-1 so requester 0 wins first after reset.
REQ-020 In IDLE req_ready, tx_we SHALL be 0; no byte is accepted in the grant cycle.
REQ-021 In BURST req_ready[grant_id] SHALL equal !tx_full combinationally; all other req_ready bits 0.
REQ-022 tx_we SHALL equal req_valid[grant_id] & req_ready[grant_id]; tx_data SHALL equal req_data of grant_id combinationally (zero latency).
REQ-023 Each accepted byte increments burst_count and clears the idle counter.
REQ-024 BURST -> IDLE at the edge where the accepted byte has req_last=1, or where burst_count reaches MAX_BURST after that acceptance; last_grant <= grant_id.
REQ-025 Idle counter increments each BURST cycle without acceptance (req_valid low or tx_full high); reaching IDLE_TIMEOUT returns to IDLE with last_grant <= grant_id.
REQ-026 tx_full held high SHALL count toward timeout; a byte accepted on the same edge the counter would expire takes priority and clears it.
REQ-027 enable falling during BURST SHALL NOT abort the burst; it only blocks the next grant.
REQ-028 A byte presented on the edge the grant ends is accepted exactly once; next requester's first byte is accepted no earlier than 2 cycles after.
REQ-029 grant_active = (state==BURST); grant_id and burst_count hold their last values in IDLE.

Reset
REQ-030 rst low SHALL immediately force state IDLE, last_grant=REQUESTERS-1, grant_id=0, burst_count=0, idle counter=0; req_ready, tx_we, grant_active 0 asynchronously.
REQ-031 Reset mid-burst SHALL drop the grant with no further writes; partial message is not resumed.

Verification
REQ-032 Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant next edge, tx_we 3 consecutive cycles with those bytes, burst_count=3, then IDLE.
REQ-033 All 4 requesters valid continuously with 1-byte messages -> grant order 0,1,2,3,0, one byte each.
REQ-034 Req1 streams 20 bytes no last, MAX_BURST=16 -> 16 writes, grant released, other pending requester granted next, req1 resumes after.
REQ-035 Req2 granted then drops valid -> IDLE after exactly 64 cycles, no writes; tx_full=1 for 64 cycles with valid high -> same release.
REQ-036 tx_full toggles high 2 cycles mid-burst -> req_ready and tx_we 0 during those cycles, no byte lost or duplicated.
REQ-037 rst asserted on 2nd byte of a 5-byte burst -> outputs 0 immediately, after release req0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of REQUESTERS byte streams access to a UART TX FIFO write port.
// Latency: grant one edge after request in IDLE; bytes pass to tx_data/tx_we combinationally during a grant.
// Backpressure: tx_full drops the granted req_ready; a grant ends on last byte, MAX_BURST bytes or IDLE_TIMEOUT stalled cycles.
module uart_tx_arbiter #(
    parameter int REQUESTERS   = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64,
    localparam int GID_W       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [REQUESTERS-1:0]   req_valid,
    input  logic [8*REQUESTERS-1:0] req_data,
    input  logic [REQUESTERS-1:0]   req_last,
    output logic [REQUESTERS-1:0]   req_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_we,
    input  logic                    tx_full,
    output logic                    grant_active,
    output logic [GID_W-1:0]        grant_id,
    output logic [7:0]              burst_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GID_W-1:0]  last_grant;
    logic [GID_W-1:0]  winner;
    logic              any_valid;
    logic [7:0]        idle_cnt;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              accept;
    logic              end_burst;
    logic              timeout;

    // Mux out the granted requester's byte, valid and last flag.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_id == GID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin search: first valid requester starting just above the last one served.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (!any_valid && req_valid[i] &&
                    (((int'(last_grant) + k) % REQUESTERS) == i)) begin
                    any_valid = 1'b1;
                    winner    = GID_W'(i);
                end
            end
        end
    end

    // A byte moves only while granted and the FIFO has room; an acceptance beats a timeout on the same edge.
    assign accept    = (state == BURST) && sel_valid && !tx_full;
    assign end_burst = accept && (sel_last || (({1'b0, burst_count} + 9'd1) == 9'(MAX_BURST)));
    assign timeout   = (state == BURST) && !accept && (({1'b0, idle_cnt} + 9'd1) == 9'(IDLE_TIMEOUT));

    assign tx_data      = sel_data;
    assign grant_active = (state == BURST);

    // Next-state and handshake outputs; nothing is accepted outside BURST.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_we     = 1'b0;
        case (state)
            IDLE: begin
                if (enable && any_valid) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                for (int i = 0; i < REQUESTERS; i++) begin
                    req_ready[i] = (grant_id == GID_W'(i)) && !tx_full;
                end
                tx_we = accept;
                if (end_burst || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping: winner capture, byte and stall counters, round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant  <= GID_W'(REQUESTERS - 1);
            grant_id    <= '0;
            burst_count <= 8'd0;
            idle_cnt    <= 8'd0;
        end else begin
            if (state == IDLE) begin
                if (enable && any_valid) begin
                    grant_id    <= winner;
                    burst_count <= 8'd0;
                    idle_cnt    <= 8'd0;
                end
            end else begin
                if (accept) begin
                    burst_count <= burst_count + 8'd1;
                    idle_cnt    <= 8'd0;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
                if (end_burst || timeout) begin
                    last_grant <= grant_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters (4 requesters, burst 16, timeout 64).
// Each requester is a simple byte source that advances when its byte is accepted.
// FIFO writes are logged at each rising edge and compared with hand-computed sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_full;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic [7:0]  burst_count;

    int tests = 0;
    int fails = 0;

    int src_len  [4];
    int src_pos  [4];
    int src_base [4];
    int src_mode [4];   // 0: no last, 1: last on final byte, 2: last on every byte

    int   wq_id  [$];
    int   wq_dat [$];
    int   wq_cyc [$];
    int   cyc_n = 0;

    uart_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_we        (tx_we),
        .tx_full      (tx_full),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .burst_count  (burst_count)
    );

    always #5 clk = ~clk;

    // Log every FIFO write with the granted id and cycle number.
    always @(posedge clk) begin
        if (tx_we === 1'b1) begin
            wq_id.push_back(int'(grant_id));
            wq_dat.push_back(int'(tx_data));
            wq_cyc.push_back(cyc_n);
        end
        cyc_n <= cyc_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (src_pos[i] < src_len[i]);
            req_data[8*i +: 8] = 8'(src_base[i] + src_pos[i]);
            req_last[i]        = (src_mode[i] == 2) ||
                                 ((src_mode[i] == 1) && (src_pos[i] == src_len[i] - 1));
        end
    endtask

    task automatic set_src(input int i, input int len, input int base, input int mode);
        src_len[i]  = len;
        src_pos[i]  = 0;
        src_base[i] = base;
        src_mode[i] = mode;
    endtask

    task automatic clear_log();
        wq_id.delete();
        wq_dat.delete();
        wq_cyc.delete();
    endtask

    // One clock: note accepted bytes before the edge, advance the sources after it.
    task automatic step();
        logic [3:0] acc;
        #1;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) src_pos[i]++;
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 0, 0, 0);
        drive();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        tx_full = 1'b0;
        for (int i = 0; i < 4; i++) set_src(i, 0, 0, 0);
        drive();
        #3;
        chk("rst_active",  32'(grant_active), 32'h0);
        chk("rst_ready",   32'(req_ready),    32'h0);
        chk("rst_we",      32'(tx_we),        32'h0);
        chk("rst_gid",     32'(grant_id),     32'h0);
        chk("rst_bcount",  32'(burst_count),  32'h0);

        // Three-byte message from requester 0.
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;
        set_src(0, 3, 'h41, 1);
        drive();
        #1;
        chk("t1_idle_ready", 32'(req_ready), 32'h0);
        chk("t1_idle_we",    32'(tx_we),     32'h0);
        step();
        chk("t1_active",  32'(grant_active), 32'h1);
        chk("t1_gid",     32'(grant_id),     32'h0);
        chk("t1_ready",   32'(req_ready),    32'h1);
        chk("t1_we",      32'(tx_we),        32'h1);
        chk("t1_data0",   32'(tx_data),      32'h41);
        step();
        chk("t1_data1",   32'(tx_data),      32'h42);
        chk("t1_bcnt1",   32'(burst_count),  32'h1);
        step();
        chk("t1_data2",   32'(tx_data),      32'h43);
        step();
        chk("t1_done",    32'(grant_active), 32'h0);
        chk("t1_bcnt3",   32'(burst_count),  32'h3);
        chk("t1_nwr",     32'(wq_dat.size()), 32'd3);
        if (wq_dat.size() == 3) begin
            chk("t1_w0",   32'(wq_dat[0]), 32'h41);
            chk("t1_w1",   32'(wq_dat[1]), 32'h42);
            chk("t1_w2",   32'(wq_dat[2]), 32'h43);
            chk("t1_cons", 32'(wq_cyc[2] - wq_cyc[0]), 32'd2);
        end

        // All four requesters pending with one-byte messages; order 0,1,2,3,0.
        do_reset();
        clear_log();
        set_src(0, 2, 'h10, 2);
        set_src(1, 1, 'h20, 2);
        set_src(2, 1, 'h30, 2);
        set_src(3, 1, 'h40, 2);
        drive();
        repeat (10) step();
        chk("t2_idle", 32'(grant_active), 32'h0);
        chk("t2_nwr",  32'(wq_dat.size()), 32'd5);
        if (wq_dat.size() == 5) begin
            chk("t2_id0", 32'(wq_id[0]), 32'd0);
            chk("t2_id1", 32'(wq_id[1]), 32'd1);
            chk("t2_id2", 32'(wq_id[2]), 32'd2);
            chk("t2_id3", 32'(wq_id[3]), 32'd3);
            chk("t2_id4", 32'(wq_id[4]), 32'd0);
            chk("t2_d4",  32'(wq_dat[4]), 32'h11);
        end

        // Requester 1 streams 20 bytes with no last; requester 3 waits with one byte.
        clear_log();
        set_src(1, 20, 'h60, 0);
        set_src(3, 1, 'h90, 1);
        drive();
        repeat (17) step();
        chk("t3_rel",    32'(grant_active), 32'h0);
        chk("t3_bcnt",   32'(burst_count),  32'd16);
        chk("t3_n16",    32'(wq_dat.size()), 32'd16);
        step();
        chk("t3_gid3",   32'(grant_id), 32'd3);
        step();
        step();
        chk("t3_gid1",   32'(grant_id), 32'd1);
        chk("t3_bclr",   32'(burst_count), 32'd0);
        repeat (4) step();
        repeat (63) step();
        chk("t3_hold",   32'(grant_active), 32'h1);
        step();
        chk("t3_tmo",    32'(grant_active), 32'h0);
        chk("t3_bcnt4",  32'(burst_count),  32'd4);
        chk("t3_nwr",    32'(wq_dat.size()), 32'd21);
        if (wq_dat.size() == 21) begin
            chk("t3_w15", 32'(wq_dat[15]), 32'h6F);
            chk("t3_i16", 32'(wq_id[16]),  32'd3);
            chk("t3_w16", 32'(wq_dat[16]), 32'h90);
            chk("t3_i17", 32'(wq_id[17]),  32'd1);
            chk("t3_w17", 32'(wq_dat[17]), 32'h70);
            chk("t3_w20", 32'(wq_dat[20]), 32'h73);
        end

        // Requester 2 granted, then drops valid: release after 64 cycles.
        clear_log();
        set_src(2, 1, 'hC0, 1);
        drive();
        step();
        chk("t4_gid",   32'(grant_id), 32'd2);
        src_len[2] = 0;
        drive();
        repeat (63) step();
        chk("t4_hold",  32'(grant_active), 32'h1);
        step();
        chk("t4_tmo",   32'(grant_active), 32'h0);
        chk("t4_nwr",   32'(wq_dat.size()), 32'd0);

        // FIFO full for the whole grant with valid high: same 64-cycle release.
        tx_full = 1'b1;
        set_src(2, 1, 'hC0, 1);
        drive();
        step();
        chk("t4f_gnt",   32'(grant_active), 32'h1);
        chk("t4f_ready", 32'(req_ready),    32'h0);
        chk("t4f_we",    32'(tx_we),        32'h0);
        repeat (63) step();
        chk("t4f_hold",  32'(grant_active), 32'h1);
        step();
        chk("t4f_tmo",   32'(grant_active), 32'h0);
        chk("t4f_nwr",   32'(wq_dat.size()), 32'd0);
        src_len[2] = 0;
        tx_full    = 1'b0;
        drive();

        // Two full cycles mid-burst with enable dropped: no loss, no duplicate, no abort.
        clear_log();
        set_src(0, 5, 'hA0, 1);
        drive();
        step();
        step();
        step();
        tx_full = 1'b1;
        enable  = 1'b0;
        #1;
        chk("t5_rdy_f1", 32'(req_ready),    32'h0);
        chk("t5_we_f1",  32'(tx_we),        32'h0);
        step();
        chk("t5_act_f2", 32'(grant_active), 32'h1);
        chk("t5_we_f2",  32'(tx_we),        32'h0);
        step();
        tx_full = 1'b0;
        #1;
        chk("t5_we_r",   32'(tx_we),   32'h1);
        chk("t5_dat_r",  32'(tx_data), 32'hA2);
        step();
        step();
        step();
        chk("t5_done",   32'(grant_active), 32'h0);
        chk("t5_bcnt",   32'(burst_count),  32'd5);
        chk("t5_nwr",    32'(wq_dat.size()), 32'd5);
        if (wq_dat.size() == 5) begin
            chk("t5_w2", 32'(wq_dat[2]), 32'hA2);
            chk("t5_w3", 32'(wq_dat[3]), 32'hA3);
            chk("t5_w4", 32'(wq_dat[4]), 32'hA4);
        end
        set_src(1, 1, 'hD0, 1);
        drive();
        step();
        step();
        chk("t5_blocked", 32'(grant_active), 32'h0);
        enable = 1'b1;
        step();
        chk("t5_regrant", 32'(grant_active), 32'h1);
        chk("t5_gid1",    32'(grant_id),     32'd1);
        step();

        // Reset while the second byte of a five-byte burst is on the bus.
        clear_log();
        set_src(0, 5, 'hB0, 1);
        drive();
        step();
        step();
        chk("t6_we_pre",  32'(tx_we),   32'h1);
        chk("t6_dat_pre", 32'(tx_data), 32'hB1);
        rst = 1'b0;
        #1;
        chk("t6_we",     32'(tx_we),        32'h0);
        chk("t6_ready",  32'(req_ready),    32'h0);
        chk("t6_active", 32'(grant_active), 32'h0);
        chk("t6_bcnt",   32'(burst_count),  32'h0);
        chk("t6_gid",    32'(grant_id),     32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_src(1, 1, 'hE0, 1);
        drive();
        #1;
        chk("t6_nwr",    32'(wq_dat.size()), 32'd1);
        step();
        chk("t6_first",  32'(grant_id), 32'd0);
        chk("t6_resume", 32'(tx_data),  32'hB1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
